// File: rtl/ts_pkg.sv
// Shared definitions for the timestamped event FIFO: widths, word layout, FSM encoding.
package ts_pkg;

   localparam int unsigned TS_W       = 16;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned TS_FLD_W   = 16;
   localparam int unsigned TS_LSB     = 0;
   localparam int unsigned SEQ_W      = 8;
   localparam int unsigned SEQ_LSB    = 16;
   localparam int unsigned EPOCH_W    = 7;
   localparam int unsigned EPOCH_LSB  = 24;
   localparam int unsigned LOST_LSB   = 31;
   localparam int unsigned LOST_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Assemble an output word {lost, epoch, seq, ts}
   function automatic logic [WORD_W-1:0] pack_word(
      input logic                lost,
      input logic [EPOCH_W-1:0]  epoch,
      input logic [SEQ_W-1:0]    seq,
      input logic [TS_FLD_W-1:0] ts
   );
      logic [WORD_W-1:0] w;
      w                        = '0;
      w[LOST_LSB]              = lost;
      w[EPOCH_LSB +: EPOCH_W]  = epoch;
      w[SEQ_LSB +: SEQ_W]      = seq;
      w[TS_LSB +: TS_FLD_W]    = ts;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head word and occupancy count.
module sync_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = ts_pkg::WORD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic                     dout_valid,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);
   import ts_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             push_ok_c, pop_ok_c;

   // Pointer/count update and look-ahead of the head word for the next cycle
   always_comb begin
      pop_ok_c  = pop && (count_q != '0);
      push_ok_c = push && ((count_q != CNT_W'(DEPTH)) || pop_ok_c);
      wr_ptr_d  = push_ok_c ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d  = pop_ok_c  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d   = count_q;
      if (push_ok_c && !pop_ok_c) begin
         count_d = CNT_W'(count_q + 1'b1);
      end else if (pop_ok_c && !push_ok_c) begin
         count_d = CNT_W'(count_q - 1'b1);
      end
      valid_d = (count_d != '0);
      if (!valid_d) begin
         dout_d = '0;
      end else if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
         dout_d = din;
      end else begin
         dout_d = mem_q[rd_ptr_d];
      end
   end

   // Storage array, no reset needed: contents are only visible through dout_q
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
      end
   end

   assign dout_valid = valid_q;
   assign dout       = dout_q;
   assign count      = count_q;

endmodule

// File: rtl/ts_event_fifo.sv
// Timestamped event capture: edge detect, epoch/seq tagging, loss tracking, run/drain FSM.
module ts_event_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TS_W  = ts_pkg::TS_W
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              start,
   input  logic [TS_W-1:0]                   ts_in,
   input  logic                              hit,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [ts_pkg::WORD_W-1:0]         out_data,
   output logic [$clog2(DEPTH):0]            fifo_count,
   output logic [ts_pkg::LOST_CNT_W-1:0]     lost_count,
   output logic                              busy
);
   import ts_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [LOST_CNT_W-1:0] LOST_MAX = '1;

   state_e                 state_q, state_d;
   logic                   hit_q, hit_d;
   logic [TS_W-1:0]        ts_prev_q, ts_prev_d;
   logic [EPOCH_W-1:0]     epoch_q, epoch_d;
   logic [SEQ_W-1:0]       seq_q, seq_d;
   logic                   lost_pend_q, lost_pend_d;
   logic [LOST_CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
   logic                   busy_q, busy_d;

   logic                   hit_edge_c, pop_c, full_c, empty_c;
   logic                   capture_c, push_c, drop_c, wrap_c;
   logic [EPOCH_W-1:0]     epoch_cur_c;
   logic [WORD_W-1:0]      word_c;

   // Event qualification, word assembly and next-state logic
   always_comb begin
      hit_edge_c  = hit & ~hit_q;
      pop_c       = out_valid & out_ready;
      full_c      = (fifo_count == CNT_W'(DEPTH));
      empty_c     = (fifo_count == '0);
      capture_c   = hit_edge_c && (state_q == ST_RUN);
      push_c      = capture_c && (!full_c || pop_c);
      drop_c      = capture_c && full_c && !pop_c;
      wrap_c      = start && (ts_in < ts_prev_q);
      epoch_cur_c = wrap_c ? EPOCH_W'(epoch_q + 1'b1) : epoch_q;
      word_c      = pack_word(lost_pend_q, epoch_cur_c, seq_q, TS_FLD_W'(ts_in));

      state_d     = state_q;
      hit_d       = hit;
      ts_prev_d   = ts_in;
      epoch_d     = epoch_cur_c;
      seq_d       = push_c ? SEQ_W'(seq_q + 1'b1) : seq_q;
      lost_pend_d = drop_c | (lost_pend_q & ~push_c);
      lost_cnt_d  = (drop_c && (lost_cnt_q != LOST_MAX)) ?
                    LOST_CNT_W'(lost_cnt_q + 1'b1) : lost_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_RUN;
               epoch_d     = '0;
               seq_d       = '0;
               lost_pend_d = 1'b0;
               lost_cnt_d  = '0;
            end
         end
         ST_RUN: begin
            if (!start) begin
               state_d = (empty_c && !push_c) ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (start) begin
               state_d = ST_RUN;
            end else if (empty_c) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and tag registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         hit_q       <= 1'b0;
         ts_prev_q   <= '0;
         epoch_q     <= '0;
         seq_q       <= '0;
         lost_pend_q <= 1'b0;
         lost_cnt_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         ts_prev_q   <= ts_prev_d;
         epoch_q     <= epoch_d;
         seq_q       <= seq_d;
         lost_pend_q <= lost_pend_d;
         lost_cnt_q  <= lost_cnt_d;
         busy_q      <= busy_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk        (CLK),
      .rst        (RST),
      .push       (push_c),
      .din        (word_c),
      .pop        (pop_c),
      .dout_valid (out_valid),
      .dout       (out_data),
      .count      (fifo_count)
   );

   assign lost_count = lost_cnt_q;
   assign busy       = busy_q;

endmodule
